regfile_dump: RTL and testbench

//  Debug readout engine for the single-cycle MIPS core. On a start pulse it

---
 rtl/regfile_dump.sv | 98 +++++++++
 tb/tb_regfile_dump.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - halts the core and streams every register as an (index, data) beat
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  // The beat is captured into registers so out_valid never depends on out_ready.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    index_d = index_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        data_d  = rf_rdata;
        index_d = idx_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cpu_halt = (state_q != IDLE);
    busy     = (state_q == READ) || (state_q == SEND);
    done     = (state_q == DONE);
    rf_raddr = busy ? idx_q : '0;
  end

  assign out_valid = valid_q;
  assign out_index = index_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed bench for the register dump engine
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;

  logic zero_r0 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  int n_beats, n_done, halt_cnt, gap_err, stalled, last_beat_c, done_c;
  bit aborted;

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(cpu_halt), .busy(busy),
    .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data)
  );

  always #5 clk = ~clk;

  assign rf_rdata = (zero_r0 && rf_raddr == 5'd0) ? 32'h0 : 32'hA500_0000 + 32'(rf_raddr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return (zero_r0 && i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i);
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_halt"},  32'(cpu_halt),  32'h0);
    check_eq({tag, "_busy"},  32'(busy),      32'h0);
    check_eq({tag, "_done"},  32'(done),      32'h0);
    check_eq({tag, "_raddr"}, 32'(rf_raddr),  32'h0);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "_index"}, 32'(out_index), 32'h0);
    check_eq({tag, "_data"},  out_data,       32'h0);
  endtask

  // Called one delta after a clock edge; drives inputs for the next edge and logs handshakes.
  task automatic collect(input int stall_at, input int stall_len, input int pulse_at,
                         input int reset_at, input bit hold_start);
    bit seen_done = 0;
    bit finished = 0;
    int prev_c = -1;
    n_beats = 0; n_done = 0; halt_cnt = 0; gap_err = 0; stalled = 0;
    last_beat_c = -1; done_c = -1; aborted = 0;
    for (int k = 0; k < 400; k++) begin
      start = hold_start;
      out_ready = 1'b1;
      if (cpu_halt) halt_cnt++;
      if (done) begin
        n_done++;
        done_c = cyc;
        seen_done = 1;
      end
      if (seen_done && !cpu_halt) begin
        finished = 1;
        break;
      end
      if (out_valid && int'(out_index) == reset_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        aborted = 1;
        finished = 1;
        break;
      end
      if (out_valid && int'(out_index) == pulse_at) start = 1'b1;
      if (out_valid && int'(out_index) == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        check_eq("stall_index", 32'(out_index), 32'(stall_at));
        check_eq("stall_data", out_data, exp_data(stall_at));
        stalled++;
      end
      if (out_valid && out_ready) begin
        check_eq("beat_index", 32'(out_index), 32'(n_beats));
        check_eq("beat_data", out_data, exp_data(n_beats));
        check_eq("beat_raddr", 32'(rf_raddr), 32'(n_beats));
        if (prev_c >= 0 && cyc - prev_c != 2) gap_err++;
        prev_c = cyc;
        last_beat_c = cyc;
        n_beats++;
      end
      step();
    end
    if (!finished) check_eq("collect_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    step(); step();
    check_all_zero("rst");
    reset = 1'b1;
    step();
    check_eq("idle_halt", 32'(cpu_halt), 32'h0);

    // Test 1: full dump with sink always ready
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t1_halt_rise", 32'(cpu_halt), 32'h1);
    collect(-1, 0, -1, -1, 0);
    check_eq("t1_beats", 32'(n_beats), 32'd32);
    check_eq("t1_done_cnt", 32'(n_done), 32'd1);
    check_eq("t1_gap_err", 32'(gap_err), 32'd0);
    check_eq("t1_done_lat", 32'(done_c - last_beat_c), 32'd1);
    check_eq("t1_halt_cycles", 32'(halt_cnt), 32'd65);

    // Test 2: back-pressure for 3 cycles on beat 5
    start = 1'b1;
    step();
    start = 1'b0;
    collect(5, 3, -1, -1, 0);
    check_eq("t2_stalled", 32'(stalled), 32'd3);
    check_eq("t2_beats", 32'(n_beats), 32'd32);
    check_eq("t2_done_cnt", 32'(n_done), 32'd1);
    check_eq("t2_halt_cycles", 32'(halt_cnt), 32'd68);

    // Test 3: start re-pulsed mid-dump is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    collect(-1, 0, 10, -1, 0);
    check_eq("t3_beats", 32'(n_beats), 32'd32);
    check_eq("t3_done_cnt", 32'(n_done), 32'd1);
    start = 1'b0;
    step();
    check_eq("t3_no_requeue", 32'(cpu_halt), 32'h0);

    // Test 4: reset during SEND of beat 12
    start = 1'b1;
    step();
    start = 1'b0;
    collect(-1, 0, -1, 12, 0);
    check_eq("t4_aborted", 32'(aborted), 32'h1);
    check_eq("t4_beats_before", 32'(n_beats), 32'd12);
    check_all_zero("t4_post_rst");
    step();
    check_eq("t4_no_done", 32'(done), 32'h0);
    check_eq("t4_idle", 32'(cpu_halt), 32'h0);

    // Test 6 (also the restart after test 4): $zero reads back as 0
    zero_r0 = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    collect(-1, 0, -1, -1, 0);
    check_eq("t6_beats", 32'(n_beats), 32'd32);
    check_eq("t6_done_cnt", 32'(n_done), 32'd1);
    zero_r0 = 1'b0;

    // Test 5: start held high gives back-to-back dumps
    start = 1'b1;
    step();
    collect(-1, 0, -1, -1, 1);
    check_eq("t5_d1_beats", 32'(n_beats), 32'd32);
    check_eq("t5_d1_done", 32'(n_done), 32'd1);
    check_eq("t5_idle_gap", 32'(cpu_halt), 32'h0);
    step();
    check_eq("t5_read_busy", 32'(busy), 32'h1);
    check_eq("t5_read_novalid", 32'(out_valid), 32'h0);
    step();
    check_eq("t5_first_valid", 32'(out_valid), 32'h1);
    check_eq("t5_first_index", 32'(out_index), 32'h0);
    start = 1'b0;
    collect(-1, 0, -1, -1, 0);
    check_eq("t5_d2_beats", 32'(n_beats), 32'd32);
    check_eq("t5_d2_done", 32'(n_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
